// File: rtl/sram_march_bist.sv
// March C- self-test initiator for one 1rw1r OpenRAM macro (or banked wrapper).
// Issues one SRAM access per cycle from registered outputs, checks read data
// through a latency-matched compare pipeline, and reports error count, first
// failing address/port, and a done/pass handshake.
module sram_march_bist #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    NUM_WMASK    = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN      = 32'h55555555,
    parameter int                    READ_LATENCY = 1,
    parameter int                    ERR_W        = 16
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  first_fail_port,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASK-1:0]  wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_e;

    // One outstanding read waiting for its data to come back.
    typedef struct packed {
        logic                  valid;
        logic [1:0]            mask;      // bit 0 = port 0, bit 1 = port 1
        logic [DATA_WIDTH-1:0] expected;
        logic [ADDR_WIDTH-1:0] addr;
    } cmp_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    function automatic logic is_march(input state_e s);
        return s inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
    endfunction

    // Elements that read then write each address.
    function automatic logic is_pair(input state_e s);
        return s inside {S_M1, S_M2, S_M3, S_M4};
    endfunction

    function automatic logic is_down(input state_e s);
        return s inside {S_M3, S_M4};
    endfunction

    function automatic state_e next_elem(input state_e s);
        case (s)
            S_M0:    return S_M1;
            S_M1:    return S_M2;
            S_M2:    return S_M3;
            S_M3:    return S_M4;
            S_M4:    return S_M5;
            default: return S_DRAIN;
        endcase
    endfunction

    // Sequencer position: the access currently on the ports.
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;   // 0 = read half, 1 = write half of a pair

    logic                  busy_q, done_q, pass_q;
    logic                  csb0_q, web0_q, csb1_q;
    logic [NUM_WMASK-1:0]  wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0] din0_q;

    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic [ERR_W:0]        err_sum;
    logic [ADDR_WIDTH-1:0] ffail_addr_q;
    logic                  ffail_port_q;

    cmp_t                  pipe_q [READ_LATENCY+1];
    cmp_t                  issue_d;
    cmp_t                  cmp_last;
    logic                  pipe_empty;
    logic                  fail0, fail1;

    logic                  op_active, op_read;
    logic [DATA_WIDTH-1:0] rd_data, wr_data;

    // Next access: advance within a pair, then address, then element.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_M0;
                    addr_d  = ADDR_ZERO;
                    phase_d = 1'b0;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (is_pair(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == (is_down(state_q) ? ADDR_ZERO : ADDR_LAST)) begin
                        state_d = next_elem(state_q);
                        addr_d  = is_down(state_d) ? ADDR_LAST : ADDR_ZERO;
                    end else begin
                        addr_d = is_down(state_q) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: if (pipe_empty) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode the next access into port values and its compare-pipeline entry.
    always_comb begin
        op_active = is_march(state_d);
        op_read   = (state_d == S_M5) || (is_pair(state_d) && !phase_d);
        rd_data   = (state_d inside {S_M2, S_M4}) ? ~PATTERN : PATTERN;
        wr_data   = (state_d inside {S_M1, S_M3}) ? ~PATTERN : PATTERN;
        issue_d          = '0;
        issue_d.valid    = op_active && op_read;
        issue_d.mask     = {state_d == S_M5, 1'b1};
        issue_d.expected = rd_data;
        issue_d.addr     = addr_d;
    end

    // Sequencer FSM with registered SRAM-side and handshake outputs.
    always_ff @(posedge clk0) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            csb1_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            din0_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            busy_q  <= is_march(state_d) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            if (state_q == S_IDLE && start) begin
                pass_q <= 1'b0;
            end else if (state_d == S_DONE) begin
                pass_q <= (err_count_q == '0);
            end
            if (op_active) begin
                csb0_q  <= 1'b0;
                web0_q  <= op_read;
                addr0_q <= addr_d;
                if (!op_read) begin
                    din0_q   <= wr_data;
                    wmask0_q <= '1;
                end
                csb1_q <= (state_d != S_M5);
                if (state_d == S_M5) addr1_q <= addr_d;
            end else begin
                csb0_q <= 1'b1;
                web0_q <= 1'b1;
                csb1_q <= 1'b1;
            end
        end
    end

    // Delay each read's expectation until its data is on dout.
    always_ff @(posedge clk0) begin
        // NOTE: this pipeline is a few flops, not a RAM, so it is reset; a stale
        // valid bit would otherwise score a phantom error after an abort.
        if (!rst_n) begin
            for (int i = 0; i <= READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= issue_d;
            for (int i = 1; i <= READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Compare returning data and form the saturating error sum.
    always_comb begin
        cmp_last   = pipe_q[READ_LATENCY];
        fail0      = cmp_last.valid && cmp_last.mask[0] && (dout0 != cmp_last.expected);
        fail1      = cmp_last.valid && cmp_last.mask[1] && (dout1 != cmp_last.expected);
        err_sum    = {1'b0, err_count_q} + {{ERR_W{1'b0}}, fail0} + {{ERR_W{1'b0}}, fail1};
        err_count_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        pipe_empty = 1'b1;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            if (pipe_q[i].valid) pipe_empty = 1'b0;
        end
    end

    // Result registers: cleared by a run start, first mismatch wins, port 0 on ties.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            err_count_q  <= '0;
            ffail_addr_q <= '0;
            ffail_port_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            err_count_q  <= '0;
            ffail_addr_q <= '0;
            ffail_port_q <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            if ((fail0 || fail1) && err_count_q == '0) begin
                ffail_addr_q <= cmp_last.addr;
                ffail_port_q <= !fail0;
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_fail_addr = ffail_addr_q;
    assign first_fail_port = ffail_port_q;
    assign csb0            = csb0_q;
    assign web0            = web0_q;
    assign wmask0          = wmask0_q;
    assign addr0           = addr0_q;
    assign din0            = din0_q;
    assign csb1            = csb1_q;
    assign addr1           = addr1_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: an 8-word behavioural 1rw1r SRAM with injectable
// faults, a March C- access-sequence model built from the element list, and a
// second instance (ERR_W=2, always-wrong read data) for counter saturation.
module tb_sram_march_bist;

    localparam int          AW    = 3;
    localparam int          DW    = 32;
    localparam int          NW    = 4;
    localparam int          EW    = 16;
    localparam int          DEPTH = 8;
    localparam int          NOPS  = 10 * DEPTH;
    localparam logic [31:0] PAT   = 32'h55555555;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic rst_n, start_a, start_b;

    logic          busy_a, done_a, pass_a, first_fail_port_a, csb0_a, web0_a, csb1_a;
    logic [EW-1:0] err_count_a;
    logic [AW-1:0] first_fail_addr_a, addr0_a, addr1_a;
    logic [NW-1:0] wmask0_a;
    logic [DW-1:0] din0_a, dout0_a, dout1_a;

    logic          busy_b, done_b, pass_b, first_fail_port_b, csb0_b, web0_b, csb1_b;
    logic [1:0]    err_count_b;
    logic [AW-1:0] first_fail_addr_b, addr0_b, addr1_b;
    logic [NW-1:0] wmask0_b;
    logic [DW-1:0] din0_b;
    logic [DW-1:0] dout0_b = '0;
    logic [DW-1:0] dout1_b = '0;

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASK(NW), .PATTERN(PAT),
                      .READ_LATENCY(1), .ERR_W(EW)) dut_a (
        .clk0(clk0), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_count_a), .first_fail_addr(first_fail_addr_a),
        .first_fail_port(first_fail_port_a), .csb0(csb0_a), .web0(web0_a),
        .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a), .dout0(dout0_a),
        .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_a));

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASK(NW), .PATTERN(PAT),
                      .READ_LATENCY(1), .ERR_W(2)) dut_b (
        .clk0(clk0), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_count_b), .first_fail_addr(first_fail_addr_b),
        .first_fail_port(first_fail_port_b), .csb0(csb0_b), .web0(web0_b),
        .wmask0(wmask0_b), .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b),
        .csb1(csb1_b), .addr1(addr1_b), .dout1(dout1_b));

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Fault modes: 1 addr5 bit0 stuck-at-1, 2 addr5 bit0 stuck-at-0,
    // 3 port 1 reads of addr2 have bit31 inverted, 4 every read returns zero.
    function automatic logic [DW-1:0] fault_read(input int mode, input bit port,
                                                 input logic [AW-1:0] a, input logic [DW-1:0] v);
        case (mode)
            1:       return (a == 3'd5) ? (v | 32'h1) : v;
            2:       return (a == 3'd5) ? (v & ~32'h1) : v;
            3:       return (port && a == 3'd2) ? (v ^ 32'h8000_0000) : v;
            4:       return '0;
            default: return v;
        endcase
    endfunction

    // Behavioural 1rw1r SRAM: inputs captured on the edge, dout valid after it.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk0) begin
        if (!csb0_a) begin
            if (!web0_a) begin
                for (int b = 0; b < NW; b++)
                    if (wmask0_a[b]) mem[addr0_a][b*8 +: 8] <= din0_a[b*8 +: 8];
            end else begin
                dout0_a <= fault_read(fault_mode, 1'b0, addr0_a, mem[addr0_a]);
            end
        end
        if (!csb1_a) dout1_a <= fault_read(fault_mode, 1'b1, addr1_a, mem[addr1_a]);
    end

    // Expected access sequence, one entry per access cycle.
    logic          op_rd   [NOPS];
    logic          op_dual [NOPS];
    logic [AW-1:0] op_addr [NOPS];
    logic [DW-1:0] op_data [NOPS];

    function automatic void build_ops();
        int k;
        k = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] rv, wv;
                a  = (e == 3 || e == 4) ? AW'(DEPTH - 1 - i) : AW'(i);
                rv = (e == 2 || e == 4) ? ~PAT : PAT;
                wv = (e == 1 || e == 3) ? ~PAT : PAT;
                if (e != 0) begin
                    op_rd[k] = 1'b1; op_dual[k] = (e == 5); op_addr[k] = a; op_data[k] = rv;
                    k++;
                end
                if (e != 5) begin
                    op_rd[k] = 1'b0; op_dual[k] = 1'b0; op_addr[k] = a; op_data[k] = wv;
                    k++;
                end
            end
        end
    endfunction

    // Result model: every read checked against its fault, port 0 before port 1.
    task automatic model_result(input int mode, input int maxv,
                                output int err, output int faddr, output int fport);
        err = 0; faddr = 0; fport = 0;
        for (int k = 0; k < NOPS; k++) begin
            if (op_rd[k]) begin
                for (int p = 0; p <= (op_dual[k] ? 1 : 0); p++) begin
                    if (fault_read(mode, p[0], op_addr[k], op_data[k]) != op_data[k]) begin
                        if (err == 0) begin faddr = int'(op_addr[k]); fport = p; end
                        if (err < maxv) err++;
                    end
                end
            end
        end
    endtask

    function automatic logic [63:0] obs_access();
        return 64'({busy_a, done_a, csb0_a, web0_a, csb1_a, addr0_a,
                    csb1_a ? {AW{1'b0}} : addr1_a,
                    web0_a ? 32'b0 : din0_a, web0_a ? 4'b0 : wmask0_a});
    endfunction

    function automatic logic [63:0] exp_access(input int k);
        logic wr;
        wr = !op_rd[k];
        return 64'({1'b1, 1'b0, 1'b0, !wr, !op_dual[k], op_addr[k],
                    op_dual[k] ? op_addr[k] : {AW{1'b0}},
                    wr ? op_data[k] : 32'b0, wr ? 4'hF : 4'h0});
    endfunction

    function automatic logic [63:0] obs_reset();
        return 64'({csb0_a, csb1_a, web0_a, busy_a, done_a, pass_a, first_fail_port_a,
                    err_count_a, first_fail_addr_a, addr0_a, addr1_a, wmask0_a, din0_a});
    endfunction

    logic [AW-1:0] tr_addr [NOPS];
    logic          tr_web  [NOPS];
    logic          tr_csb1 [NOPS];
    logic [DW-1:0] tr_din  [NOPS];

    // One run on dut_a with per-cycle comparison; optional re-pulse or abort.
    task automatic run_a(input string tag, input int mode, input int repulse_at, input int reset_at);
        int m_err, m_addr, m_port, c, dones;
        fault_mode = mode;
        model_result(mode, 65535, m_err, m_addr, m_port);
        @(negedge clk0) start_a = 1'b1;
        @(negedge clk0) start_a = 1'b0;
        for (int k = 0; k < NOPS; k++) begin
            check({tag, " access"}, obs_access(), exp_access(k));
            tr_addr[k] = addr0_a; tr_web[k] = web0_a; tr_csb1[k] = csb1_a; tr_din[k] = din0_a;
            start_a = (k == repulse_at);
            if (k == reset_at) begin
                check({tag, " err before abort"}, 64'(err_count_a), 64'd2);
                rst_n = 1'b0;
                @(negedge clk0);
                check({tag, " state after abort"}, obs_reset(), 64'({3'b111, 65'b0}) >> 1);
                rst_n   = 1'b1;
                start_a = 1'b0;
                dones   = 0;
                repeat (100) begin
                    @(negedge clk0);
                    if (done_a) dones++;
                end
                check({tag, " no done after abort"}, 64'(dones), 64'd0);
                return;
            end
            @(negedge clk0);
        end
        start_a = 1'b0;
        c = 0;
        while (!done_a && c < 16) begin
            check({tag, " drain idle"}, 64'({busy_a, csb0_a, csb1_a, web0_a}), 64'hF);
            @(negedge clk0);
            c++;
        end
        check({tag, " done seen"}, 64'(done_a), 64'd1);
        check({tag, " busy at done"}, 64'(busy_a), 64'd0);
        check({tag, " err_count"}, 64'(err_count_a), 64'(m_err));
        check({tag, " first_fail_addr"}, 64'(first_fail_addr_a), 64'(m_addr));
        check({tag, " first_fail_port"}, 64'(first_fail_port_a), 64'(m_port));
        check({tag, " pass"}, 64'(pass_a), 64'(m_err == 0));
        @(negedge clk0);
        check({tag, " done one cycle"}, 64'({done_a, busy_a}), 64'd0);
        check({tag, " pass held"}, 64'(pass_a), 64'(m_err == 0));
    endtask

    int me, ma, mp, c;

    initial begin
        build_ops();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk0);
        check("reset values", obs_reset(), 64'({3'b111, 65'b0}) >> 1);
        rst_n = 1'b1;
        @(negedge clk0);

        // Model pins: M3 runs downward, M5 is the only dual-port element.
        check("model M3 first addr", 64'(op_addr[40]), 64'd7);
        check("model M5 dual", 64'({op_dual[71], op_dual[72]}), 64'b01);

        run_a("clean", 0, -1, -1);
        check("clean lit err", 64'(err_count_a), 64'd0);
        check("clean lit pass", 64'(pass_a), 64'd1);
        check("M3 r addr7", 64'({tr_addr[40], tr_web[40]}), 64'({3'd7, 1'b1}));
        check("M3 w addr7", 64'({tr_addr[41], tr_web[41], tr_din[41]}), 64'({3'd7, 1'b0, 32'hAAAAAAAA}));
        check("M3 r addr6", 64'({tr_addr[42], tr_web[42]}), 64'({3'd6, 1'b1}));
        check("M3 w addr0", 64'({tr_addr[55], tr_web[55]}), 64'({3'd0, 1'b0}));
        check("csb1 M4/M5 edge", 64'({tr_csb1[71], tr_csb1[72]}), 64'b10);

        // PATTERN bit 0 is 1, so stuck-at-1 fails only the r1 reads (M2, M4).
        run_a("sa1_addr5", 1, -1, -1);
        model_result(1, 65535, me, ma, mp);
        check("sa1 model", 64'({me[7:0], ma[7:0], mp[7:0]}), 64'h02_05_00);
        check("sa1 lit", 64'({err_count_a, first_fail_addr_a, first_fail_port_a, pass_a}),
              64'({16'd2, 3'd5, 1'b0, 1'b0}));

        // Stuck-at-0 fails r0 in M1, M3 and both ports in M5.
        run_a("sa0_addr5", 2, -1, -1);
        model_result(2, 65535, me, ma, mp);
        check("sa0 model", 64'({me[7:0], ma[7:0], mp[7:0]}), 64'h04_05_00);
        check("sa0 lit", 64'({err_count_a, first_fail_addr_a, first_fail_port_a, pass_a}),
              64'({16'd4, 3'd5, 1'b0, 1'b0}));

        run_a("port1_addr2", 3, -1, -1);
        model_result(3, 65535, me, ma, mp);
        check("p1 model", 64'({me[7:0], ma[7:0], mp[7:0]}), 64'h01_02_01);
        check("p1 lit", 64'({err_count_a, first_fail_addr_a, first_fail_port_a, pass_a}),
              64'({16'd1, 3'd2, 1'b1, 1'b0}));

        run_a("repulse_M2", 0, 30, -1);
        run_a("abort_M4", 2, -1, 60);
        run_a("after_abort", 0, -1, -1);

        // Saturation on the ERR_W=2 instance with all reads wrong.
        model_result(4, 3, me, ma, mp);
        check("sat model", 64'({me[7:0], ma[7:0], mp[7:0]}), 64'h03_00_00);
        @(negedge clk0) start_b = 1'b1;
        @(negedge clk0) start_b = 1'b0;
        c = 0;
        while (!done_b && c < 200) begin
            @(negedge clk0);
            c++;
        end
        check("sat done seen", 64'(done_b), 64'd1);
        check("sat err_count", 64'(err_count_b), 64'd3);
        check("sat first fail", 64'({first_fail_addr_b, first_fail_port_b, pass_b}),
              64'({3'd0, 1'b0, 1'b0}));
        check("sat vs model", 64'(err_count_b), 64'(me));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
